mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, in the execute stage beside the combinational ALU.
- The ALU ignores its MULT opcode; the execute stage routes MULT/MULTU (and optionally DIV/DIVU) plus MTHI/MTLO here, stalls on busy, and reads HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits. Must be even and at least 4. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request strobe, sampled when req_ready=1.
- req_op  input  3  operation: 0 MULT, 1 MULTU, 2 MTHI, 3 MTLO, 4 DIV, 5 DIVU, 6-7 illegal.
- opr1  input  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO source.
- opr2  input  WIDTH  rt value: multiplier or divisor.
- flush  input  1  pipeline flush or exception; aborts any operation in flight.
- req_ready  output  1  equals ~busy; combinational.
- busy  output  1  iterative operation in progress; registered.
- done  output  1  one-cycle pulse when HI/LO take a MULT/DIV result; registered.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- illegal_op  output  1  one-cycle registered pulse for a rejected op.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - hi=0, lo=0, busy=0, done=0, illegal_op=0.
  - State is IDLE and the iteration counter is 0.
- State machine: IDLE, CALC, FIXUP.
- IDLE with req_valid and no flush, at edge k:
  - MTHI: hi<=opr1. MTLO: lo<=opr1. Stay in IDLE, no busy, no done.
  - MULT/MULTU/DIV/DIVU: latch the operands and go to CALC. busy<=1, counter<=0.
  - Signed ops latch absolute values and record the result signs.
  - Illegal op: illegal_op<=1 for one cycle. No state change.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide.
  - Counter increments each cycle. After WIDTH steps, at edge k+WIDTH, go to FIXUP.
- FIXUP, at edge k+WIDTH+1:
  - Apply sign correction and write hi/lo. done<=1 for one cycle, busy<=0, go to IDLE.
  - Default WIDTH gives result visible 33 edges after acceptance.
- Multiply result: the 2*WIDTH product, with hi = upper half and lo = lower half.
- Signed multiply: the product is negated if the operand signs differ. Two's complement over 2*WIDTH bits.
- Divide result: lo=quotient, hi=remainder.
- Signed divide:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend (truncating division).
  - Overflow case -2^(WIDTH-1) / -1: lo=0x80000000, hi=0.
- Divide by zero: completes with normal latency. lo=all ones, hi=opr1 as given, sign correction bypassed.
- While busy:
  - req_ready=0 and requests are ignored.
  - MTHI/MTLO do not alter hi/lo, and illegal_op is not raised.
- flush, any state: next edge returns to IDLE with busy=0 and done=0. hi/lo are unchanged.
- flush together with req_valid in IDLE: flush wins and the request is dropped.
- Flush in the same cycle as FIXUP: result discarded, no done.
- done and a new request can overlap: a request accepted in the done cycle starts a new operation normally.
- Reset asserted mid-operation: immediate return to reset values, no done.
- hi/lo change only on MTHI/MTLO acceptance, FIXUP, or reset.

Optional Feature:
- Macro: MULT_DIV_UNIT_DIV_EN.
- Defined: ops 4/5 perform DIV/DIVU as specified above.
- Undefined:
  - Ops 4/5 are treated as illegal: illegal_op pulses, no state change.
  - No divider datapath (restoring subtractor, remainder register) is synthesised.
  - All multiply behaviour is identical.

Test Plan:
- After reset, MULT opr1=0xFFFFFFFF, opr2=0x00000002 -> busy for 33 cycles, then done pulse with hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Back-to-back MTLO 0x12345678 in the done cycle -> lo=0x12345678 next cycle, hi unchanged.
- Issue MULT 3x4, assert flush at iteration 10 -> busy falls next edge, no done, hi/lo keep prior values. MTHI 0xAAAA5555 issued while busy -> ignored, hi unchanged.
- req_op=7 in IDLE -> illegal_op one-cycle pulse, busy=0, hi/lo unchanged. Flush coincident with MULT req_valid -> request dropped, busy stays 0.
- With MULT_DIV_UNIT_DIV_EN: DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 5/0 -> lo=0xFFFFFFFF, hi=5.
- Without MULT_DIV_UNIT_DIV_EN: req_op=4 -> illegal_op pulse, no busy. Async rst_n low mid-MULT -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit owning the HI/LO registers.
// MULT/MULTU take WIDTH shift-add steps. MTHI/MTLO write HI/LO directly.
// Optional macro MULT_DIV_UNIT_DIV_EN adds DIV/DIVU using a restoring divider.
// Without the macro, ops 4/5 are rejected as illegal.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             flush,
  output logic             req_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             illegal_op
);

  localparam int CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpMthi  = 3'd2;
  localparam logic [2:0] OpMtlo  = 3'd3;
  localparam logic [2:0] OpDiv   = 3'd4;
`ifdef MULT_DIV_UNIT_DIV_EN
  localparam logic [2:0] OpDivu  = 3'd5;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  accHi_q, accHi_d;
  logic [WIDTH-1:0]  accLo_q, accLo_d;
  logic              negRes_q, negRes_d;
`ifdef MULT_DIV_UNIT_DIV_EN
  logic              isDiv_q, isDiv_d;
  logic              negRem_q, negRem_d;
  logic              divZero_q, divZero_d;
  logic [WIDTH-1:0]  dividend_q, dividend_d;
  logic [WIDTH:0]    divShift;
  logic              divGeq;
  logic [WIDTH-1:0]  divDiff;
`endif

  logic              signedOp;
  logic              negSign;
  logic [WIDTH-1:0]  abs1;
  logic [WIDTH-1:0]  abs2;
  logic [WIDTH:0]    mulSum;
  logic [2*WIDTH-1:0] prodRaw;
  logic [2*WIDTH-1:0] prodFinal;

  // Operand preparation: signed ops work on magnitudes and remember the result sign
  assign signedOp = (req_op == OpMult) || (req_op == OpDiv);
  assign negSign  = signedOp && (opr1[WIDTH-1] ^ opr2[WIDTH-1]);
  assign abs1     = (signedOp && opr1[WIDTH-1]) ? -opr1 : opr1;
  assign abs2     = (signedOp && opr2[WIDTH-1]) ? -opr2 : opr2;

  // Shift-add step: multiplier sits in accLo and shifts out LSB-first into the product
  assign mulSum    = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign prodRaw   = {accHi_q, accLo_q};
  assign prodFinal = negRes_q ? -prodRaw : prodRaw;

`ifdef MULT_DIV_UNIT_DIV_EN
  // Restoring step: partial remainder in accHi, dividend shifts out of accLo MSB-first
  assign divShift = {accHi_q, accLo_q[WIDTH-1]};
  assign divGeq   = divShift >= {1'b0, mcand_q};
  assign divDiff  = divShift[WIDTH-1:0] - mcand_q;
`endif

  // Next-state and datapath control; flush overrides everything except HI/LO
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    mcand_d   = mcand_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    negRes_d  = negRes_q;
`ifdef MULT_DIV_UNIT_DIV_EN
    isDiv_d    = isDiv_q;
    negRem_d   = negRem_q;
    divZero_d  = divZero_q;
    dividend_d = dividend_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          case (req_op)
            OpMthi: hi_d = opr1;
            OpMtlo: lo_d = opr1;
            OpMult, OpMultu: begin
              state_d  = CALC;
              busy_d   = 1'b1;
              cnt_d    = '0;
              mcand_d  = abs2;
              accHi_d  = '0;
              accLo_d  = abs1;
              negRes_d = negSign;
`ifdef MULT_DIV_UNIT_DIV_EN
              isDiv_d  = 1'b0;
`endif
            end
`ifdef MULT_DIV_UNIT_DIV_EN
            OpDiv, OpDivu: begin
              state_d    = CALC;
              busy_d     = 1'b1;
              cnt_d      = '0;
              mcand_d    = abs2;
              accHi_d    = '0;
              accLo_d    = abs1;
              negRes_d   = negSign;
              negRem_d   = signedOp && opr1[WIDTH-1];
              divZero_d  = (opr2 == '0);
              dividend_d = opr1;
              isDiv_d    = 1'b1;
            end
`endif
            default: illegal_d = 1'b1;
          endcase
        end
      end

      CALC: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastStep) begin
          state_d = FIXUP;
        end
`ifdef MULT_DIV_UNIT_DIV_EN
        if (isDiv_q) begin
          accHi_d = divGeq ? divDiff : divShift[WIDTH-1:0];
          accLo_d = {accLo_q[WIDTH-2:0], divGeq};
        end else begin
          accHi_d = mulSum[WIDTH:1];
          accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
        end
`else
        accHi_d = mulSum[WIDTH:1];
        accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
`endif
      end

      FIXUP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef MULT_DIV_UNIT_DIV_EN
        if (isDiv_q) begin
          if (divZero_q) begin
            lo_d = '1;
            hi_d = dividend_q;
          end else begin
            lo_d = negRes_q ? -accLo_q : accLo_q;
            hi_d = negRem_q ? -accHi_q : accHi_q;
          end
        end else begin
          {hi_d, lo_d} = prodFinal;
        end
`else
        {hi_d, lo_d} = prodFinal;
`endif
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (flush) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      cnt_d     = '0;
      hi_d      = hi_q;
      lo_d      = lo_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      negRes_q  <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
      isDiv_q    <= 1'b0;
      negRem_q   <= 1'b0;
      divZero_q  <= 1'b0;
      dividend_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      mcand_q   <= mcand_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      negRes_q  <= negRes_d;
`ifdef MULT_DIV_UNIT_DIV_EN
      isDiv_q    <= isDiv_d;
      negRem_q   <= negRem_d;
      divZero_q  <= divZero_d;
      dividend_q <= dividend_d;
`endif
    end
  end

  assign req_ready  = ~busy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit against an
// arithmetic reference model. Divide tests are enabled with MULT_DIV_UNIT_DIV_EN.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int Latency = W + 1;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic [2:0]    req_op;
  logic [W-1:0]  opr1;
  logic [W-1:0]  opr2;
  logic          flush;
  logic          req_ready;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          illegal_op;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] expHi;
  logic [W-1:0] expLo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .opr1      (opr1),
    .opr2      (opr2),
    .flush     (flush),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .illegal_op(illegal_op)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference multiply: full 2W-bit product, {hi, lo}
  function automatic logic [2*W-1:0] modelMul(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [2*W-1:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Reference divide: {remainder, quotient} with truncating signed semantics
  function automatic logic [2*W-1:0] modelDiv(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Drive one request for exactly one clock edge; returns #1 after that edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    opr1      = a;
    opr2      = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Count edges until done is seen (bounded); -1 on timeout
  task automatic waitDone(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 4 * Latency);
    if (!done) n = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi got %h expected %h", hi, 32'd0); end
    checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo got %h expected %h", lo, 32'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal got %b expected 0", illegal_op); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", req_ready); end
    rst_n = 1'b1;
    expHi = '0;
    expLo = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult_latency;
    int n;
    int busyCycles;
    logic [2*W-1:0] r;
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    busyCycles = 0;
    n = 0;
    while (busy && n < 4 * Latency) begin
      busyCycles++;
      if (done) break;
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (busyCycles !== Latency) begin errors++; $display("[TB] FAIL mult_busy_cycles got %0d expected %0d", busyCycles, Latency); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL mult_done_after_busy got %b expected 1", done); end
    r = modelMul(1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
    expHi = r[2*W-1:W];
    expLo = r[W-1:0];
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi got %h expected %h", hi, 32'hFFFF_FFFF); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mult_lo got %h expected %h", lo, 32'hFFFF_FFFE); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_pulse got %b expected 0", done); end
  endtask

  task automatic test_multu_mtlo;
    int n;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(n);
    checks++; if (n !== Latency) begin errors++; $display("[TB] FAIL multu_latency got %0d expected %0d", n, Latency); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL multu_hi got %h expected %h", hi, 32'hFFFF_FFFE); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("[TB] FAIL multu_lo got %h expected %h", lo, 32'h0000_0001); end
    expHi = 32'hFFFF_FFFE;
    issue(3'd3, 32'h1234_5678, 32'h0);
    expLo = 32'h1234_5678;
    checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL mtlo_lo got %h expected %h", lo, expLo); end
    checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL mtlo_hi got %h expected %h", hi, expHi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_busy got %b expected 0", busy); end
  endtask

  task automatic test_flush;
    int doneSeen;
    issue(3'd0, 32'd3, 32'd4);
    repeat (5) begin @(posedge clk); #1; end
    issue(3'd2, 32'hAAAA_5555, 32'h0);
    checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL busy_mthi_hi got %h expected %h", hi, expHi); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL busy_mthi_illegal got %b expected 0", illegal_op); end
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy got %b expected 0", busy); end
    doneSeen = 0;
    repeat (2 * Latency) begin
      if (done) doneSeen++;
      @(posedge clk);
      #1;
    end
    checks++; if (doneSeen !== 0) begin errors++; $display("[TB] FAIL flush_no_done got %0d expected 0", doneSeen); end
    checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL flush_hi got %h expected %h", hi, expHi); end
    checks++; if (lo !== expLo) begin errors++; $display("[TB] FAIL flush_lo got %h expected %h", lo, expLo); end
  endtask

  task automatic test_fixup_flush;
    issue(3'd1, 32'd7, 32'd9);
    repeat (W) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL fixup_flush_done got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL fixup_flush_busy got %b expected 0", busy); end
    checks++; if (hi !== expHi || lo !== expLo) begin errors++; $display("[TB] FAIL fixup_flush_hilo got %h_%h expected %h_%h", hi, lo, expHi, expLo); end
  endtask

  task automatic test_illegal;
    logic [2:0] bad [2];
    bad[0] = 3'd7;
    bad[1] = 3'd6;
    foreach (bad[i]) begin
      issue(bad[i], 32'hDEAD_BEEF, 32'h1);
      checks++; if (illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse op %0d got %b expected 1", bad[i], illegal_op); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_busy op %0d got %b expected 0", bad[i], busy); end
      @(posedge clk);
      #1;
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL illegal_one_cycle op %0d got %b expected 0", bad[i], illegal_op); end
      checks++; if (hi !== expHi || lo !== expLo) begin errors++; $display("[TB] FAIL illegal_hilo got %h_%h expected %h_%h", hi, lo, expHi, expLo); end
    end
`ifndef MULT_DIV_UNIT_DIV_EN
    issue(3'd4, 32'd100, 32'd7);
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL nodiv_illegal got %b expected 1", illegal_op); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nodiv_busy got %b expected 0", busy); end
    issue(3'd5, 32'd100, 32'd7);
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL nodivu_illegal got %b expected 1", illegal_op); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nodivu_busy got %b expected 0", busy); end
`endif
    flush = 1'b1;
    issue(3'd0, 32'd5, 32'd6);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_req_busy got %b expected 0", busy); end
    flush = 1'b1;
    issue(3'd2, 32'h5555_AAAA, 32'h0);
    flush = 1'b0;
    checks++; if (hi !== expHi) begin errors++; $display("[TB] FAIL flush_mthi_hi got %h expected %h", hi, expHi); end
  endtask

  task automatic test_mult_random;
    int n;
    logic [2:0] op;
    logic [W-1:0] a, b;
    logic [2*W-1:0] r;
    logic [W-1:0] corner [4];
    corner[0] = 32'h8000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h0;
    corner[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 1));
      a = (i % 4 == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = (i % 5 == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      issue(op, a, b);
      waitDone(n);
      r = modelMul(op == 3'd0, a, b);
      expHi = r[2*W-1:W];
      expLo = r[W-1:0];
      checks++; if (n !== Latency) begin errors++; $display("[TB] FAIL rnd_mul_latency got %0d expected %0d", n, Latency); end
      checks++; if (hi !== expHi || lo !== expLo) begin errors++; $display("[TB] FAIL rnd_mul op %0d %h*%h got %h_%h expected %h_%h", op, a, b, hi, lo, expHi, expLo); end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [W-1:0] a, b;
    logic [2*W-1:0] r;
    issue(3'd0, 32'hFFFF_FFF0, 32'd123);
    waitDone(n);
    a = $urandom;
    b = $urandom;
    issue(3'd1, a, b);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy got %b expected 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_drop got %b expected 0", done); end
    waitDone(n);
    r = modelMul(1'b0, a, b);
    expHi = r[2*W-1:W];
    expLo = r[W-1:0];
    checks++; if (n !== Latency) begin errors++; $display("[TB] FAIL b2b_latency got %0d expected %0d", n, Latency); end
    checks++; if (hi !== expHi || lo !== expLo) begin errors++; $display("[TB] FAIL b2b_result got %h_%h expected %h_%h", hi, lo, expHi, expLo); end
  endtask

`ifdef MULT_DIV_UNIT_DIV_EN
  task automatic test_div;
    int n;
    logic [2:0] op;
    logic [W-1:0] a, b;
    logic [2*W-1:0] r;
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    waitDone(n);
    checks++; if (n !== Latency) begin errors++; $display("[TB] FAIL div_latency got %0d expected %0d", n, Latency); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_neg7_2 got %h_%h expected ffffffff_fffffffd", hi, lo); end
    issue(3'd5, 32'd100, 32'd7);
    waitDone(n);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("[TB] FAIL divu_100_7 got %h_%h expected 00000002_0000000e", hi, lo); end
    issue(3'd4, 32'd5, 32'd0);
    waitDone(n);
    checks++; if (n !== Latency) begin errors++; $display("[TB] FAIL div0_latency got %0d expected %0d", n, Latency); end
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin errors++; $display("[TB] FAIL div_5_0 got %h_%h expected 00000005_ffffffff", hi, lo); end
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(n);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin errors++; $display("[TB] FAIL div_overflow got %h_%h expected 00000000_80000000", hi, lo); end
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(4, 5));
      a = $urandom;
      case (i % 4)
        0: b = 32'($urandom_range(0, 9));
        1: b = -32'($urandom_range(1, 9));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      issue(op, a, b);
      waitDone(n);
      r = modelDiv(op == 3'd4, a, b);
      expHi = r[2*W-1:W];
      expLo = r[W-1:0];
      checks++; if (hi !== expHi || lo !== expLo) begin errors++; $display("[TB] FAIL rnd_div op %0d %h/%h got %h_%h expected %h_%h", op, a, b, hi, lo, expHi, expLo); end
    end
  endtask
`endif

  task automatic test_async_reset;
    int doneSeen;
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (8) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("[TB] FAIL async_rst_hilo got %h_%h expected 0_0", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_busy got %b expected 0", busy); end
    #3;
    rst_n = 1'b1;
    expHi = '0;
    expLo = '0;
    doneSeen = 0;
    repeat (2 * Latency) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    checks++; if (doneSeen !== 0) begin errors++; $display("[TB] FAIL async_rst_no_done got %0d expected 0", doneSeen); end
  endtask

  // Test sequence
  initial begin
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    opr1      = '0;
    opr2      = '0;
    flush     = 1'b0;
    expHi     = '0;
    expLo     = '0;
    #3;
    test_reset();
    test_mult_latency();
    test_multu_mtlo();
    test_flush();
    test_fixup_flush();
    test_illegal();
    test_mult_random();
    test_back_to_back();
`ifdef MULT_DIV_UNIT_DIV_EN
    test_div();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
